// File: rtl/booth_mul_sched_pkg.sv
// Shared widths and the in-flight tag type for the Booth multiplier scheduler.
package booth_mul_sched_pkg;

  localparam int OPW     = 4;
  localparam int RESW    = 9;
  // Wide enough for the largest requester count (8).
  localparam int TAG_IDW = 3;

  typedef struct packed {
    logic               vld;
    logic [TAG_IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/sched_rsp_fifo.sv
// In-order response FIFO built as a shift register so the head entry is always a flop.
module sched_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 11,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic          head_valid_o,
  output logic [DW-1:0] head_data_o,
  output logic [CW-1:0] count_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  // Pop shifts every entry toward the head; a push lands just past the last live entry.
  always_comb begin
    int wr_idx;
    do_pop  = pop_i && (count_q != '0);
    count_d = count_q + CW'(push_i) - CW'(do_pop);
    for (int k = 0; k < DEPTH; k++) begin
      mem_d[k] = mem_q[k];
    end
    if (do_pop) begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        mem_d[k] = mem_q[k + 1];
      end
      mem_d[DEPTH-1] = '0;
    end
    wr_idx = int'(count_q) - (do_pop ? 1 : 0);
    if (push_i && (wr_idx < DEPTH)) begin
      mem_d[wr_idx] = push_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= mem_d[k];
      end
    end
  end

  assign head_valid_o = (count_q != '0);
  assign head_data_o  = mem_q[0];
  assign count_o      = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !do_pop && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/booth_mul_sched.sv
// Round-robin scheduler sharing one external 4x4 multiplier among NREQ clients,
// with credit-protected in-order response return.
module booth_mul_sched
  import booth_mul_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MUL_LAT   = 2,
  parameter int RSP_DEPTH = 4,
  parameter int IDW       = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [4*NREQ-1:0]   req_a,
  input  logic [4*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic [OPW-1:0]      mul_x,
  output logic [OPW-1:0]      mul_m,
  input  logic [RESW-1:0]     mul_result,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [RESW-1:0]     rsp_result,
  input  logic                rsp_ready,
  output logic                busy
);

  localparam int CRW = $clog2(RSP_DEPTH + 1);
  localparam int FCW = $clog2(RSP_DEPTH + 1);

  logic [CRW-1:0]      cred_q, cred_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [IDW-1:0]      gnt_id;
  logic                gnt_found;
  logic [NREQ-1:0]     grant;
  logic                issue;
  logic                rsp_hs;
  logic [OPW-1:0]      mul_x_q, mul_x_d, mul_m_q, mul_m_d;
  tag_t                tag_q [MUL_LAT];
  tag_t                tag_d [MUL_LAT];
  tag_t                tag_last;
  logic                tag_any;
  logic [FCW-1:0]      fifo_count;
  logic [IDW+RESW-1:0] fifo_head;
  logic                unused_tag_id;

  // First valid requester at or after ptr, wrapping; grant only while a FIFO slot is unreserved.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(idx);
      end
    end
    grant = '0;
    if (gnt_found && (cred_q != '0) && !rst) begin
      grant[gnt_id] = 1'b1;
    end
  end

  assign req_ready = grant;
  assign issue     = |grant;
  assign rsp_hs    = rsp_valid && rsp_ready;

  always_comb begin
    cred_d  = cred_q - CRW'(issue) + CRW'(rsp_hs);
    ptr_d   = ptr_q;
    mul_x_d = mul_x_q;
    mul_m_d = mul_m_q;
    if (issue) begin
      ptr_d   = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
      mul_x_d = req_a[gnt_id*OPW +: OPW];
      mul_m_d = req_b[gnt_id*OPW +: OPW];
    end
  end

  // Tag pipe mirrors the datapath latency; a bubble enters on cycles without issue.
  always_comb begin
    tag_d[0].vld = issue;
    tag_d[0].id  = issue ? TAG_IDW'(gnt_id) : '0;
    for (int k = 1; k < MUL_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end
    tag_any = 1'b0;
    for (int k = 0; k < MUL_LAT; k++) begin
      tag_any = tag_any | tag_q[k].vld;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cred_q  <= CRW'(RSP_DEPTH);
      ptr_q   <= '0;
      mul_x_q <= '0;
      mul_m_q <= '0;
      for (int k = 0; k < MUL_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      cred_q  <= cred_d;
      ptr_q   <= ptr_d;
      mul_x_q <= mul_x_d;
      mul_m_q <= mul_m_d;
      for (int k = 0; k < MUL_LAT; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign tag_last      = tag_q[MUL_LAT-1];
  assign unused_tag_id = ^tag_last.id;

  sched_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .DW    (IDW + RESW),
    .CW    (FCW)
  ) u_rsp_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (tag_last.vld),
    .push_data_i  ({tag_last.id[IDW-1:0], mul_result}),
    .pop_i        (rsp_ready),
    .head_valid_o (rsp_valid),
    .head_data_o  (fifo_head),
    .count_o      (fifo_count)
  );

  assign rsp_id     = fifo_head[IDW+RESW-1:RESW];
  assign rsp_result = fifo_head[RESW-1:0];
  assign mul_x      = mul_x_q;
  assign mul_m      = mul_m_q;
  assign busy       = tag_any | (fifo_count != '0);

  a_cred_max: assert property (@(posedge clk) disable iff (rst) cred_q <= CRW'(RSP_DEPTH));
  a_cred_min: assert property (@(posedge clk) disable iff (rst) !(issue && (cred_q == '0)));

endmodule

// File: tb/tb_booth_mul_sched.sv
// Scoreboard bench for booth_mul_sched with a two-stage behavioural multiplier datapath.
module tb_booth_mul_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int RESW = 9;
  localparam int W    = IDW + RESW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [3:0]        mul_x;
  logic [3:0]        mul_m;
  logic [RESW-1:0]   mul_result = '0;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [RESW-1:0]   rsp_result;
  logic              rsp_ready;
  logic              busy;

  int checks   = 0;
  int failures = 0;
  int n_issue  = 0;
  int n_rsp    = 0;

  logic [W-1:0]    exp_q[$];
  logic [IDW-1:0]  gnt_q[$];
  logic [RESW-1:0] exp_prod [NREQ];

  booth_mul_sched dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .mul_x      (mul_x),
    .mul_m      (mul_m),
    .mul_result (mul_result),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  // Clock and datapath model: product valid one cycle after the operand registers update.
  always #5 clk = ~clk;

  always @(posedge clk) mul_result <= {5'b0, mul_x} * {5'b0, mul_m};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                         input logic [RESW-1:0] p);
    req_a[i*4 +: 4] = a;
    req_b[i*4 +: 4] = b;
    exp_prod[i]     = p;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    next_cyc();
    next_cyc();
    exp_q.delete();
    gnt_q.delete();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk(name, done, 1'b1);
  endtask

  // Monitor: pushes expectations on request handshakes, pops and compares on response handshakes.
  logic [IDW-1:0]  gid;
  logic            prev_vld, prev_rdy;
  logic [IDW-1:0]  prev_id;
  logic [RESW-1:0] prev_res;

  always @(negedge clk) begin
    if (rst) begin
      prev_vld = 1'b0;
    end else begin
      chk("grant_onehot", $onehot0(req_ready), 1'b1);
      chk("grant_subset", req_ready & ~req_valid, 0);
      if (|(req_valid & req_ready)) begin
        gid = '0;
        for (int i = 0; i < NREQ; i++) begin
          if (req_valid[i] && req_ready[i]) gid = IDW'(i);
        end
        n_issue++;
        exp_q.push_back({gid, exp_prod[gid]});
        if (gnt_q.size() > 0) chk("grant_order", gid, gnt_q.pop_front());
      end
      if (prev_vld && !prev_rdy) begin
        chk("rsp_hold", {rsp_valid, rsp_id, rsp_result}, {1'b1, prev_id, prev_res});
      end
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        if (exp_q.size() == 0) chk("rsp_unexpected", exp_q.size(), 1);
        else chk("rsp_data", {rsp_id, rsp_result}, exp_q.pop_front());
      end
      prev_vld = rsp_valid;
      prev_rdy = rsp_ready;
      prev_id  = rsp_id;
      prev_res = rsp_result;
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int base;
    int lat;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) exp_prod[i] = '0;

    // Reset values, with requests pending during reset
    #1;
    req_valid = 4'hF;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mul_x", mul_x, 0);
    chk("rst_mul_m", mul_m, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_busy", busy, 0);
    next_cyc();
    rst       = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 0);

    // Single request, requester 2: 7*9
    next_cyc();
    set_req(2, 4'd7, 4'd9, 9'd63);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("single_grant", req_ready, 4'b0100);
    next_cyc();
    req_valid = '0;
    chk("single_mul_x", mul_x, 7);
    chk("single_mul_m", mul_m, 9);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    chk("single_latency", lat, 3);
    chk("single_rsp_id", rsp_id, 2);
    chk("single_rsp_result", rsp_result, 63);
    drain("single_drain");

    // Round-robin with all requesters valid; credit stays at 1 while issuing and popping
    do_reset();
    set_req(0, 4'd3,  4'd5,  9'd15);
    set_req(1, 4'd6,  4'd6,  9'd36);
    set_req(2, 4'd10, 4'd11, 9'd110);
    set_req(3, 4'd12, 4'd2,  9'd24);
    gnt_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_throughput", |req_ready, 1'b1);
      next_cyc();
    end
    req_valid = '0;
    chk("rr_grants_consumed", gnt_q.size(), 0);
    drain("rr_drain");

    // Backpressure: four credits, then stall; resume one cycle after the first pop
    do_reset();
    rsp_ready = 1'b0;
    base      = n_issue;
    gnt_q     = '{2'd0, 2'd1, 2'd2, 2'd3};
    req_valid = 4'hF;
    repeat (8) next_cyc();
    @(negedge clk);
    chk("bp_issue_count", n_issue - base, 4);
    chk("bp_stall", req_ready, 0);
    chk("bp_head_valid", rsp_valid, 1'b1);
    chk("bp_head_id", rsp_id, 0);
    next_cyc();
    rsp_ready = 1'b1;
    gnt_q     = '{2'd0, 2'd1};
    @(negedge clk);
    chk("bp_pop_cycle_no_issue", req_ready, 0);
    next_cyc();
    @(negedge clk);
    chk("bp_resume", req_ready, 4'b0001);
    next_cyc();
    @(negedge clk);
    next_cyc();
    req_valid = '0;
    drain("bp_drain");

    // Operand extremes
    do_reset();
    set_req(0, 4'd0,  4'd13, 9'd0);
    set_req(1, 4'd15, 4'd15, 9'd225);
    set_req(3, 4'd8,  4'd1,  9'd8);
    gnt_q     = '{2'd0, 2'd1, 2'd3};
    req_valid = 4'b1011;
    repeat (3) next_cyc();
    req_valid = '0;
    chk("ext_grants_consumed", gnt_q.size(), 0);
    drain("ext_drain");

    // Reset one cycle after two issues
    do_reset();
    req_valid = 4'b0011;
    repeat (2) next_cyc();
    req_valid = '0;
    chk("mid_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_req_ready", req_ready, 0);
    chk("mid_mul_x", mul_x, 0);
    chk("mid_mul_m", mul_m, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_rsp_id", rsp_id, 0);
    chk("mid_rsp_result", rsp_result, 0);
    chk("mid_busy", busy, 0);
    exp_q.delete();
    repeat (2) next_cyc();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", rsp_valid, 0);
    end
    next_cyc();
    rsp_ready = 1'b0;
    base      = n_issue;
    gnt_q     = '{2'd0, 2'd1, 2'd2, 2'd3};
    req_valid = 4'hF;
    repeat (8) next_cyc();
    chk("post_rst_credits", n_issue - base, 4);
    req_valid = '0;
    rsp_ready = 1'b1;
    drain("post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
